uart_slave_wb: RTL and testbench

//  Wishbone B3 classic slave exposing a UART register bank to the MIPS Wishbone master bridge.

---
 rtl/uart_wb_pkg.sv | 26 ++
 rtl/uart_slave_wb_if.sv | 24 ++
 rtl/wb_sync_fifo.sv | 53 +++++
 rtl/uart_slave_wb.sv | 150 +++++++++++++++
 tb/tb_uart_slave_wb.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_wb_pkg.sv
// Shared register offsets, STATUS/CTRL bit positions and TX FSM encoding
// for the Wishbone UART slave.
package uart_wb_pkg;

   localparam logic [1:0] REG_TXDATA = 2'd0;
   localparam logic [1:0] REG_RXDATA = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;

   localparam int ST_RX_FULL  = 0;
   localparam int ST_TX_EMPTY = 1;
   localparam int ST_TX_FULL  = 2;
   localparam int ST_RX_OVF   = 3;
   localparam int ST_TX_OVF   = 4;

   localparam int CTRL_RX_IRQ = 0;
   localparam int CTRL_TX_IRQ = 1;

   typedef enum logic [1:0] {
      TX_IDLE      = 2'd0,
      TX_START     = 2'd1,
      TX_WAIT_BUSY = 2'd2,
      TX_WAIT_DONE = 2'd3
   } tx_state_e;

endpackage

// File: rtl/uart_slave_wb_if.sv
// Wishbone B3 classic slave bus plus the event pulse returned to the master.
interface uart_slave_wb_if;

   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic [31:0] wbs_dat_o;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_ack_o;
   logic        wbs_done_pls_o;

   modport master (
      output wbs_adr_i, wbs_dat_i, wbs_we_i, wbs_sel_i, wbs_cyc_i, wbs_stb_i,
      input  wbs_dat_o, wbs_ack_o, wbs_done_pls_o
   );

   modport slave (
      input  wbs_adr_i, wbs_dat_i, wbs_we_i, wbs_sel_i, wbs_cyc_i, wbs_stb_i,
      output wbs_dat_o, wbs_ack_o, wbs_done_pls_o
   );

endinterface

// File: rtl/wb_sync_fifo.sv
// Single-clock FIFO; push to full and pop from empty are ignored.
// Pointers wrap naturally because DEPTH is a power of two.
module wb_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      full     = (count_q == (AW+1)'(DEPTH));
      empty    = (count_q == '0);
      do_push  = push & ~full;
      do_pop   = pop & ~empty;
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      dout     = mem_q[rd_ptr_q];
      count    = count_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/uart_slave_wb.sv
// Wishbone slave register bank in front of a byte UART: TX FIFO + sender FSM,
// single-byte RX holding register, status/control and the master event pulse.
module uart_slave_wb
   import uart_wb_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE = 32'h0000_1000,
   parameter int          TX_DEPTH  = 4,
   parameter int          TX_AW     = 2
) (
   input  logic            clk,
   input  logic            rst,
   uart_slave_wb_if.slave  wb,
   output logic [7:0]      tx_data_o,
   output logic            tx_start_o,
   input  logic            tx_busy_i,
   input  logic [7:0]      rx_data_i,
   input  logic            rx_valid_i
);

   logic        ack_q, ack_d;
   logic [31:0] dat_q, dat_d;
   logic        done_q, done_d;
   logic [7:0]  rx_byte_q, rx_byte_d;
   logic        rx_full_q, rx_full_d;
   logic        rx_ovf_q, rx_ovf_d;
   logic        tx_ovf_q, tx_ovf_d;
   logic [1:0]  ctrl_q, ctrl_d;
   logic [7:0]  tx_data_q, tx_data_d;
   tx_state_e   state_q, state_d;

   logic        req, hit, wr, rd, rx_pop, push_req, fifo_push, fifo_pop, drained;
   logic [1:0]  off;
   logic [31:0] status, rdata;
   logic        tx_full, tx_empty;
   logic [7:0]  fifo_head;
   logic [TX_AW:0] fifo_count;
   logic        unused_ok;

   wb_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH), .AW(TX_AW)) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .din   (wb.wbs_dat_i[7:0]),
      .pop   (fifo_pop),
      .dout  (fifo_head),
      .full  (tx_full),
      .empty (tx_empty),
      .count (fifo_count)
   );

   assign unused_ok = ^{wb.wbs_adr_i[1:0], wb.wbs_dat_i[31:8], wb.wbs_sel_i[3:1], fifo_count};

   // Bus decode; every side effect is qualified by req so it lands on the ack edge.
   always_comb begin
      req      = wb.wbs_cyc_i & wb.wbs_stb_i & ~ack_q;
      hit      = (wb.wbs_adr_i[31:4] == ADDR_BASE[31:4]);
      off      = wb.wbs_adr_i[3:2];
      wr       = req & wb.wbs_we_i & wb.wbs_sel_i[0] & hit;
      rd       = req & ~wb.wbs_we_i & hit;
      rx_pop   = rd & (off == REG_RXDATA);
      push_req = wr & (off == REG_TXDATA);
      fifo_push = push_req & ~tx_full;

      status              = '0;
      status[ST_RX_FULL]  = rx_full_q;
      status[ST_TX_EMPTY] = tx_empty;
      status[ST_TX_FULL]  = tx_full;
      status[ST_RX_OVF]   = rx_ovf_q;
      status[ST_TX_OVF]   = tx_ovf_q;

      unique case (off)
         REG_RXDATA: rdata = {24'b0, rx_byte_q};
         REG_STATUS: rdata = status;
         REG_CTRL:   rdata = {30'b0, ctrl_q};
         default:    rdata = '0;
      endcase

      ack_d = req;
      dat_d = rd ? rdata : '0;

      rx_byte_d = rx_valid_i ? rx_data_i : rx_byte_q;
      rx_full_d = rx_valid_i ? 1'b1 : (rx_pop ? 1'b0 : rx_full_q);

      // Clear-then-set so a coincident overrun is never lost.
      rx_ovf_d = rx_ovf_q;
      if (wr && off == REG_STATUS && wb.wbs_dat_i[ST_RX_OVF]) rx_ovf_d = 1'b0;
      if (rx_valid_i && rx_full_q && !rx_pop) rx_ovf_d = 1'b1;

      tx_ovf_d = tx_ovf_q;
      if (wr && off == REG_STATUS && wb.wbs_dat_i[ST_TX_OVF]) tx_ovf_d = 1'b0;
      if (push_req && tx_full) tx_ovf_d = 1'b1;

      ctrl_d = (wr && off == REG_CTRL) ? wb.wbs_dat_i[1:0] : ctrl_q;
   end

   always_comb begin
      state_d   = state_q;
      tx_data_d = tx_data_q;
      fifo_pop  = 1'b0;
      drained   = 1'b0;
      unique case (state_q)
         TX_IDLE: if (!tx_empty) begin
            tx_data_d = fifo_head;
            fifo_pop  = 1'b1;
            state_d   = TX_START;
         end
         TX_START:     state_d = TX_WAIT_BUSY;
         TX_WAIT_BUSY: if (tx_busy_i) state_d = TX_WAIT_DONE;
         TX_WAIT_DONE: if (!tx_busy_i) begin
            state_d = TX_IDLE;
            drained = tx_empty;
         end
         default:      state_d = TX_IDLE;
      endcase
      done_d = (rx_valid_i & ctrl_q[CTRL_RX_IRQ]) | (drained & ctrl_q[CTRL_TX_IRQ]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_q     <= 1'b0;
         dat_q     <= '0;
         done_q    <= 1'b0;
         rx_byte_q <= '0;
         rx_full_q <= 1'b0;
         rx_ovf_q  <= 1'b0;
         tx_ovf_q  <= 1'b0;
         ctrl_q    <= '0;
         tx_data_q <= '0;
         state_q   <= TX_IDLE;
      end else begin
         ack_q     <= ack_d;
         dat_q     <= dat_d;
         done_q    <= done_d;
         rx_byte_q <= rx_byte_d;
         rx_full_q <= rx_full_d;
         rx_ovf_q  <= rx_ovf_d;
         tx_ovf_q  <= tx_ovf_d;
         ctrl_q    <= ctrl_d;
         tx_data_q <= tx_data_d;
         state_q   <= state_d;
      end
   end

   assign wb.wbs_ack_o      = ack_q;
   assign wb.wbs_dat_o      = dat_q;
   assign wb.wbs_done_pls_o = done_q;
   assign tx_data_o         = tx_data_q;
   assign tx_start_o        = (state_q == TX_START);

endmodule

// File: tb/tb_uart_slave_wb.sv
// Directed bench for uart_slave_wb: bus timing, TX FIFO/FSM, RX register, events, reset.
module tb_uart_slave_wb;

   localparam logic [31:0] TXD = 32'h0000_1000;
   localparam logic [31:0] RXD = 32'h0000_1004;
   localparam logic [31:0] STS = 32'h0000_1008;
   localparam logic [31:0] CTL = 32'h0000_100C;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_slave_wb_if wb();

   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy;
   logic       busy_auto = 1'b0;
   logic       busy_man  = 1'b0;
   logic       auto_mode = 1'b1;
   logic [7:0] rx_data   = 8'h00;
   logic       rx_valid  = 1'b0;

   assign tx_busy = auto_mode ? busy_auto : busy_man;

   uart_slave_wb #(.ADDR_BASE(32'h0000_1000), .TX_DEPTH(4), .TX_AW(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .wb         (wb),
      .tx_data_o  (tx_data),
      .tx_start_o (tx_start),
      .tx_busy_i  (tx_busy),
      .rx_data_i  (rx_data),
      .rx_valid_i (rx_valid)
   );

   int checks = 0;
   int errors = 0;
   int n_done = 0;
   int start_busy = 0;
   logic [7:0] starts[$];

   always @(negedge clk) begin
      if (wb.wbs_done_pls_o) n_done++;
      if (tx_start) begin
         starts.push_back(tx_data);
         if (tx_busy) start_busy++;
      end
   end

   // Simple transmitter: busy 2 cycles after start, for 6 cycles.
   initial begin
      forever begin
         @(negedge clk);
         if (tx_start && auto_mode) begin
            repeat (2) @(negedge clk);
            busy_auto = 1'b1;
            repeat (6) @(negedge clk);
            busy_auto = 1'b0;
         end
      end
   end

   task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rdat);
      bit got = 1'b0;
      @(negedge clk);
      wb.wbs_adr_i = adr;
      wb.wbs_dat_i = dat;
      wb.wbs_we_i  = we;
      wb.wbs_sel_i = sel;
      wb.wbs_cyc_i = 1'b1;
      wb.wbs_stb_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (wb.wbs_ack_o) begin got = 1'b1; break; end
      end
      rdat = wb.wbs_dat_o;
      wb.wbs_cyc_i = 1'b0;
      wb.wbs_stb_i = 1'b0;
      wb.wbs_we_i  = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL bus_ack_timeout adr=%h: no ack within 8 cycles", adr);
      end
   endtask

   task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
      logic [31:0] d;
      bus(1'b1, adr, dat, 4'hF, d);
   endtask

   task automatic rd(input logic [31:0] adr, output logic [31:0] d);
      bus(1'b0, adr, 32'h0, 4'hF, d);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({wb.wbs_ack_o, wb.wbs_dat_o, wb.wbs_done_pls_o, tx_data, tx_start} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got ack=%b dat=%h done=%b txd=%h start=%b, want all 0",
                  wb.wbs_ack_o, wb.wbs_dat_o, wb.wbs_done_pls_o, tx_data, tx_start);
      end
      rst = 1'b0;
      @(negedge clk);
      wb.wbs_adr_i = STS; wb.wbs_we_i = 1'b0; wb.wbs_sel_i = 4'hF;
      wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (wb.wbs_ack_o !== 1'b1 || wb.wbs_dat_o !== 32'h02) begin
         errors++;
         $display("FAIL reset_status_read: got ack=%b dat=%h, want ack=1 dat=00000002",
                  wb.wbs_ack_o, wb.wbs_dat_o);
      end
      @(posedge clk); #1;
      checks++;
      if (wb.wbs_ack_o !== 1'b0) begin
         errors++;
         $display("FAIL ack_single_cycle: got ack=%b with stb still high, want 0", wb.wbs_ack_o);
      end
      wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
   endtask

   task automatic test_tx_two();
      int s0, d0, b0;
      wr(CTL, 32'h2);
      s0 = starts.size(); d0 = n_done; b0 = start_busy;
      wr(TXD, 32'h41);
      wr(TXD, 32'h42);
      repeat (60) @(negedge clk);
      checks++;
      if (starts.size() - s0 != 2 || starts[s0] !== 8'h41 || starts[s0+1] !== 8'h42) begin
         errors++;
         $display("FAIL tx_two_bytes: got %0d starts, want 2 starts with 41 then 42", starts.size() - s0);
      end
      checks++;
      if (start_busy != b0) begin
         errors++;
         $display("FAIL tx_start_while_busy: got %0d, want 0", start_busy - b0);
      end
      checks++;
      if (n_done - d0 != 1) begin
         errors++;
         $display("FAIL tx_drain_pulse: got %0d pulses, want 1", n_done - d0);
      end
      checks++;
      if (tx_data !== 8'h42) begin
         errors++;
         $display("FAIL tx_data_hold: got %h, want 42", tx_data);
      end
      wr(CTL, 32'h0);
   endtask

   task automatic test_tx_full();
      int s0;
      logic [31:0] d;
      auto_mode = 1'b0; busy_man = 1'b1;
      s0 = starts.size();
      for (int b = 1; b <= 5; b++) wr(TXD, 32'(b));
      repeat (3) @(negedge clk);
      rd(STS, d);
      checks++;
      if (d !== 32'h04 || starts.size() - s0 != 1) begin
         errors++;
         $display("FAIL tx_full_status: got sts=%h starts=%0d, want sts=00000004 starts=1", d, starts.size() - s0);
      end
      wr(TXD, 32'h06);
      rd(STS, d);
      checks++;
      if (d !== 32'h14) begin
         errors++;
         $display("FAIL tx_ovf_set: got %h, want 00000014", d);
      end
      wr(STS, 32'h10);
      rd(STS, d);
      checks++;
      if (d !== 32'h04) begin
         errors++;
         $display("FAIL tx_ovf_clear: got %h, want 00000004", d);
      end
      busy_man = 1'b0; auto_mode = 1'b1;
      repeat (100) @(negedge clk);
      rd(STS, d);
      checks++;
      if (starts.size() - s0 != 5 || starts[$] !== 8'h05 || d !== 32'h02) begin
         errors++;
         $display("FAIL tx_full_drain: got starts=%0d last=%h sts=%h, want 5 last=05 sts=00000002",
                  starts.size() - s0, starts[$], d);
      end
   endtask

   task automatic pulse_rx(input logic [7:0] b);
      @(negedge clk);
      rx_data = b; rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic test_rx_irq();
      int d0;
      logic [31:0] d;
      wr(CTL, 32'h1);
      d0 = n_done;
      pulse_rx(8'h5A);
      repeat (3) @(negedge clk);
      checks++;
      if (n_done - d0 != 1) begin
         errors++;
         $display("FAIL rx_irq_pulse: got %0d pulses, want 1", n_done - d0);
      end
      rd(RXD, d);
      checks++;
      if (d !== 32'h5A) begin
         errors++;
         $display("FAIL rx_read: got %h, want 0000005a", d);
      end
      rd(STS, d);
      checks++;
      if (d !== 32'h02) begin
         errors++;
         $display("FAIL rx_full_clear: got %h, want 00000002", d);
      end
      wr(CTL, 32'h0);
   endtask

   task automatic test_rx_ovf();
      logic [31:0] d;
      pulse_rx(8'h11);
      pulse_rx(8'h22);
      rd(RXD, d);
      checks++;
      if (d !== 32'h22) begin
         errors++;
         $display("FAIL rx_overwrite: got %h, want 00000022", d);
      end
      rd(STS, d);
      checks++;
      if (d !== 32'h0A) begin
         errors++;
         $display("FAIL rx_ovf_set: got %h, want 0000000a", d);
      end
      wr(STS, 32'h08);
      pulse_rx(8'h33);
      // RXDATA pop on the same edge as a new byte
      @(negedge clk);
      wb.wbs_adr_i = RXD; wb.wbs_we_i = 1'b0; wb.wbs_sel_i = 4'hF;
      wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1;
      rx_data = 8'h44; rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      checks++;
      if (wb.wbs_ack_o !== 1'b1 || wb.wbs_dat_o !== 32'h33) begin
         errors++;
         $display("FAIL rx_pop_collide_read: got ack=%b dat=%h, want ack=1 dat=00000033",
                  wb.wbs_ack_o, wb.wbs_dat_o);
      end
      wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
      rd(STS, d);
      checks++;
      if (d !== 32'h03) begin
         errors++;
         $display("FAIL rx_pop_collide_status: got %h, want 00000003", d);
      end
      rd(RXD, d);
      checks++;
      if (d !== 32'h44) begin
         errors++;
         $display("FAIL rx_pop_collide_new: got %h, want 00000044", d);
      end
   endtask

   task automatic test_decode_reset();
      int s0;
      logic [31:0] d;
      rd(32'h0000_1020, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL miss_read_20: got %h, want 00000000", d);
      end
      rd(32'h0000_1028, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL miss_read_28: got %h, want 00000000", d);
      end
      wr(32'h0000_102C, 32'h3);
      bus(1'b1, CTL, 32'h3, 4'hE, d);
      rd(CTL, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL ctrl_no_write: got %h, want 00000000", d);
      end
      bus(1'b1, CTL, 32'hFF, 4'h1, d);
      rd(CTL, d);
      checks++;
      if (d !== 32'h3) begin
         errors++;
         $display("FAIL ctrl_write: got %h, want 00000003", d);
      end
      auto_mode = 1'b0; busy_man = 1'b1;
      wr(TXD, 32'h77);
      wr(TXD, 32'h88);
      wr(TXD, 32'h99);
      repeat (3) @(negedge clk);
      checks++;
      if (tx_data !== 8'h77) begin
         errors++;
         $display("FAIL pre_reset_txdata: got %h, want 77", tx_data);
      end
      s0 = starts.size();
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({wb.wbs_ack_o, wb.wbs_dat_o, wb.wbs_done_pls_o, tx_data, tx_start} !== '0) begin
         errors++;
         $display("FAIL midop_reset: got ack=%b dat=%h done=%b txd=%h start=%b, want all 0",
                  wb.wbs_ack_o, wb.wbs_dat_o, wb.wbs_done_pls_o, tx_data, tx_start);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0; busy_man = 1'b0; auto_mode = 1'b1;
      repeat (10) @(negedge clk);
      rd(STS, d);
      checks++;
      if (d !== 32'h02 || starts.size() != s0) begin
         errors++;
         $display("FAIL post_reset_empty: got sts=%h new_starts=%0d, want 00000002 and 0",
                  d, starts.size() - s0);
      end
      rd(CTL, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL post_reset_ctrl: got %h, want 00000000", d);
      end
   endtask

   initial begin
      wb.wbs_adr_i = '0; wb.wbs_dat_i = '0; wb.wbs_we_i = 1'b0;
      wb.wbs_sel_i = '0; wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
      test_reset();
      test_tx_two();
      test_tx_full();
      test_rx_irq();
      test_rx_ovf();
      test_decode_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
